slow_clock_monitor: RTL and testbench

Measures the period of a slow, asynchronous square-wave clock (nominally the 4 Hz board clock) in units of the 100 MHz system clock. It reports lock when the period stays inside a tolerance window and reports loss when edges stop arriving. It sits in the system clock domain, on the receiving side of the slow-clock divider, and feeds status LEDs and any logic that must qualify the slow clock before use.

---
 rtl/slow_clock_monitor.sv | 191 +++++++++++++++++++
 tb/tb_slow_clock_monitor.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/slow_clock_monitor.sv
// slow_clock_monitor: measures the period of an asynchronous slow clock in
// clk_i cycles, qualifies it against a tolerance window, and flags lock/loss.
//
// Ports:
//   clk_i          system clock (only clock)
//   rst_i          synchronous active-high reset
//   slow_i         monitored slow clock, asynchronous to clk_i
//   rise_o         one-cycle pulse per synchronized rising edge of slow_i
//   period_o       most recent measured period (held between updates)
//   period_valid_o one-cycle pulse when period_o updates
//   range_err_o    one-cycle pulse when a measured period is out of range
//   locked_o       lock status
//   lost_o         loss status, sticky until the next rising edge
module slow_clock_monitor #(
    parameter int unsigned PERIOD_NOM = 25_000_002,
    parameter int unsigned TOL        = 250_000,
    parameter int unsigned LOCK_N     = 4,
    parameter int unsigned TIMEOUT    = 50_000_004,
    parameter int unsigned CW         = 28
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          slow_i,
    output logic          rise_o,
    output logic [CW-1:0] period_o,
    output logic          period_valid_o,
    output logic          range_err_o,
    output logic          locked_o,
    output logic          lost_o
);

    localparam int unsigned GW = $clog2(LOCK_N + 1);

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam longint unsigned CNT_MAX_L = (longint'(1) << CW) - 1;
    localparam logic [CW-1:0] P_LO = CW'(PERIOD_NOM - TOL);
    localparam logic [CW-1:0] P_HI = CW'(PERIOD_NOM + TOL);
    // A timeout beyond the counter range could never be matched once the
    // counter saturates, so it is clamped to the saturation value.
    localparam logic [CW-1:0] TMO_C =
        (longint'(TIMEOUT) >= CNT_MAX_L) ? CNT_MAX : CW'(TIMEOUT);
    localparam logic [GW-1:0] GOOD_N = GW'(LOCK_N);

    typedef enum logic [1:0] {
        IDLE,
        ACQ,
        LOCKED,
        LOST
    } state_e;

    state_e        state_q, state_d;
    logic          s1_q, s2_q, s3_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] good_q, good_d;
    logic          rise_q, rise_d;
    logic [CW-1:0] period_q, period_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          locked_q, locked_d;
    logic          lost_q, lost_d;

    logic          rise;
    logic          in_range;
    logic          tmo;
    logic [GW-1:0] good_inc;

    always_comb begin
        rise     = s2_q & ~s3_q;
        in_range = (cnt_q >= P_LO) && (cnt_q <= P_HI);
        tmo      = (cnt_q == TMO_C);
        good_inc = good_q + 1'b1;

        // Saturating interval counter, restarted by each edge.
        if (rise) begin
            cnt_d = CW'(1);
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        state_d  = state_q;
        good_d   = good_q;
        rise_d   = rise;
        period_d = period_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        locked_d = locked_q;
        lost_d   = lost_q;

        unique case (state_q)
            IDLE: begin
                // First edge has no start point, so nothing is reported.
                if (rise) begin
                    state_d = ACQ;
                end else if (tmo) begin
                    state_d = LOST;
                    lost_d  = 1'b1;
                end
            end
            ACQ: begin
                if (rise) begin
                    period_d = cnt_q;
                    valid_d  = 1'b1;
                    err_d    = ~in_range;
                    if (in_range) begin
                        good_d = good_inc;
                        if (good_inc == GOOD_N) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        good_d = '0;
                    end
                end else if (tmo) begin
                    state_d  = LOST;
                    lost_d   = 1'b1;
                    locked_d = 1'b0;
                    good_d   = '0;
                end
            end
            LOCKED: begin
                if (rise) begin
                    period_d = cnt_q;
                    valid_d  = 1'b1;
                    err_d    = ~in_range;
                    if (!in_range) begin
                        state_d  = ACQ;
                        locked_d = 1'b0;
                        good_d   = '0;
                    end
                end else if (tmo) begin
                    state_d  = LOST;
                    lost_d   = 1'b1;
                    locked_d = 1'b0;
                    good_d   = '0;
                end
            end
            LOST: begin
                locked_d = 1'b0;
                good_d   = '0;
                // The interval spans the outage, so it is not reported.
                if (rise) begin
                    state_d = ACQ;
                    lost_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            cnt_q    <= '0;
            good_q   <= '0;
            rise_q   <= 1'b0;
            period_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            s1_q     <= slow_i;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            cnt_q    <= cnt_d;
            good_q   <= good_d;
            rise_q   <= rise_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            locked_q <= locked_d;
            lost_q   <= lost_d;
        end
    end

    assign rise_o         = rise_q;
    assign period_o       = period_q;
    assign period_valid_o = valid_q;
    assign range_err_o    = err_q;
    assign locked_o       = locked_q;
    assign lost_o         = lost_q;

endmodule

// File: tb/tb_slow_clock_monitor.sv
// tb_slow_clock_monitor: scoreboard bench for slow_clock_monitor.
// Expected periods are queued at stimulus time and popped on period_valid_o.
module tb_slow_clock_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, slow;
    logic       rise, pv, re, lk, ls;
    logic [7:0] per;

    logic       rst2, slow2;
    logic       rise2, pv2, re2, lk2, ls2;
    logic [5:0] per2;

    slow_clock_monitor #(
        .PERIOD_NOM(20), .TOL(2), .LOCK_N(3), .TIMEOUT(40), .CW(8)
    ) dut (
        .clk_i(clk), .rst_i(rst), .slow_i(slow),
        .rise_o(rise), .period_o(per), .period_valid_o(pv),
        .range_err_o(re), .locked_o(lk), .lost_o(ls)
    );

    slow_clock_monitor #(
        .PERIOD_NOM(20), .TOL(2), .LOCK_N(3), .TIMEOUT(70), .CW(6)
    ) dut2 (
        .clk_i(clk), .rst_i(rst2), .slow_i(slow2),
        .rise_o(rise2), .period_o(per2), .period_valid_o(pv2),
        .range_err_o(re2), .locked_o(lk2), .lost_o(ls2)
    );

    typedef struct packed {
        logic [7:0] per;
        logic       err;
        logic       lk;
    } exp_t;

    exp_t q[$];
    exp_t q2[$];
    exp_t e, e2;

    int n_cmp = 0;
    int n_bad = 0;
    int rise_seen = 0;
    int rise_exp = 0;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard whenever a period is presented.
    always @(negedge clk) begin
        if (rise) rise_seen++;
        if (pv) begin
            if (q.size() == 0) begin
                chk("unexpected period_valid_o", 1, 0);
            end else begin
                e = q.pop_front();
                chk("period_o", int'(per), int'(e.per));
                chk("range_err_o", int'(re), int'(e.err));
                chk("locked_o at valid", int'(lk), int'(e.lk));
            end
        end else if (re) begin
            chk("range_err_o without valid", 1, 0);
        end
        if (pv2) begin
            if (q2.size() == 0) begin
                chk("dut2 unexpected period_valid_o", 1, 0);
            end else begin
                e2 = q2.pop_front();
                chk("dut2 period_o", int'(per2), int'(e2.per));
                chk("dut2 range_err_o", int'(re2), int'(e2.err));
            end
        end
    end

    task automatic push(input int p, input bit err, input bit l);
        exp_t x;
        x.per = p[7:0];
        x.err = err;
        x.lk  = l;
        q.push_back(x);
    endtask

    task automatic pulse(input int hi, input int lo);
        slow = 1'b1;
        rise_exp++;
        repeat (hi) @(negedge clk);
        slow = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    // Rise that must report period p (the interval ending at this rise).
    task automatic rpt(input int p, input bit err, input bit l,
                       input int hi, input int lo);
        push(p, err, l);
        pulse(hi, lo);
    endtask

    // Rise with no period report; checks latency and lost_o clearing.
    task automatic first_edge(input int hi, input int lo, input bit lost_b);
        slow = 1'b1;
        rise_exp++;
        repeat (2) @(negedge clk);
        chk("rise_o before E2", int'(rise), 0);
        chk("lost_o before rise", int'(ls), int'(lost_b));
        @(negedge clk);
        chk("rise_o at E2", int'(rise), 1);
        chk("lost_o at rise", int'(ls), 0);
        repeat (hi - 3) @(negedge clk);
        slow = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    // Last rise before an outage; checks loss timing from rise_o.
    task automatic outage(input int p, input bit err, input bit l);
        int k;
        push(p, err, l);
        slow = 1'b1;
        rise_exp++;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!rise && k < 8);
        chk("rise_o before outage", int'(rise), 1);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 7) slow = 1'b0;
            if (i == 39) begin
                chk("lost_o one cycle early", int'(ls), 0);
                chk("locked_o before loss", int'(lk), 1);
            end
            if (i == 40) begin
                chk("lost_o at timeout", int'(ls), 1);
                chk("locked_o at loss", int'(lk), 0);
            end
        end
    endtask

    initial begin
        exp_t x;
        rst   = 1'b1;
        slow  = 1'b0;
        rst2  = 1'b1;
        slow2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset rise_o", int'(rise), 0);
        chk("reset period_o", int'(per), 0);
        chk("reset valid", int'(pv), 0);
        chk("reset locked_o", int'(lk), 0);
        chk("reset lost_o", int'(ls), 0);
        rst = 1'b0;

        // No activity: loss after 41 edges.
        for (int i = 1; i <= 41; i++) begin
            @(negedge clk);
            if (i == 40) chk("idle lost_o at 40", int'(ls), 0);
            if (i == 41) chk("idle lost_o at 41", int'(ls), 1);
        end
        chk("idle locked_o", int'(lk), 0);
        chk("idle rise count", rise_seen, 0);

        // Clean input and lock.
        first_edge(10, 10, 1'b1);
        rpt(20, 0, 0, 10, 10);
        rpt(20, 0, 0, 10, 10);
        rpt(20, 0, 1, 10, 8);
        // Window edges.
        rpt(18, 0, 1, 11, 11);
        rpt(22, 0, 1, 9, 8);
        rpt(17, 1, 0, 10, 10);
        rpt(20, 0, 0, 10, 10);
        rpt(20, 0, 0, 12, 11);
        rpt(23, 1, 0, 10, 10);
        rpt(20, 0, 0, 10, 10);
        rpt(20, 0, 0, 10, 10);
        rpt(20, 0, 1, 13, 12);
        // Disturbance while locked.
        rpt(25, 1, 0, 10, 10);
        rpt(20, 0, 0, 10, 10);
        rpt(20, 0, 0, 10, 10);
        // Outage while locked, then restart.
        outage(20, 0, 1);
        repeat (20) @(negedge clk);
        first_edge(10, 10, 1'b1);
        rpt(20, 0, 0, 10, 10);
        rpt(20, 0, 0, 10, 10);
        rpt(20, 0, 1, 10, 10);

        // Reset while locked.
        chk("locked before reset", int'(lk), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid reset locked_o", int'(lk), 0);
        chk("mid reset period_o", int'(per), 0);
        chk("mid reset lost_o", int'(ls), 0);
        chk("mid reset rise_o", int'(rise), 0);
        chk("mid reset valid", int'(pv), 0);
        rst = 1'b0;
        first_edge(10, 10, 1'b0);
        rpt(20, 0, 0, 10, 10);
        repeat (5) @(negedge clk);
        chk("scoreboard drained", q.size(), 0);
        chk("rise_o count", rise_seen, rise_exp);

        // Saturation with CW=6.
        rst2 = 1'b0;
        slow2 = 1'b1;
        repeat (3) @(negedge clk);
        chk("dut2 first rise_o", int'(rise2), 1);
        repeat (7) @(negedge clk);
        slow2 = 1'b0;
        repeat (93) @(negedge clk);
        chk("dut2 cnt saturated", int'(dut2.cnt_q), 63);
        chk("dut2 lost_o", int'(ls2), 1);
        repeat (5) @(negedge clk);
        chk("dut2 cnt holds", int'(dut2.cnt_q), 63);
        slow2 = 1'b1;
        repeat (2) @(negedge clk);
        chk("dut2 lost_o before rise", int'(ls2), 1);
        @(negedge clk);
        chk("dut2 rise_o", int'(rise2), 1);
        chk("dut2 lost_o cleared", int'(ls2), 0);
        repeat (7) @(negedge clk);
        slow2 = 1'b0;
        repeat (10) @(negedge clk);
        x.per = 8'd20;
        x.err = 1'b0;
        x.lk  = 1'b0;
        q2.push_back(x);
        slow2 = 1'b1;
        repeat (10) @(negedge clk);
        slow2 = 1'b0;
        repeat (5) @(negedge clk);
        chk("dut2 scoreboard drained", q2.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
